// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit signed ALU between NUM_REQ valid/ready requesters.
// Optional macro ALU_RR_ARBITER_DIVZERO_CHECK_EN: op 011 with B == 0 returns 0 and raises rsp_err.

module ALU (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_y
);
  logic signed [15:0] w_as, w_bs, w_bdiv, w_q, w_r, w_t;
  logic signed [31:0] w_a32, w_b32;

  assign w_as   = i_a;
  assign w_bs   = i_b;
  assign w_a32  = 32'(w_as);
  assign w_b32  = 32'(w_bs);
  // Divisor forced to 1 on zero so the divider never sees an undefined operand.
  assign w_bdiv = (i_b == 16'd0) ? 16'sd1 : w_bs;
  assign w_q    = w_as / w_bdiv;
  assign w_r    = w_as % w_bdiv;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_t = '0;
    o_y = '0;
    case (i_op)
      3'b000: o_y = w_a32 + w_b32;
      3'b001: o_y = w_a32 - w_b32;
      3'b010: o_y = w_a32 * w_b32;
      3'b011: o_y = (i_b == 16'd0) ? 32'd0 : {w_q, w_r};
      3'b100: begin w_t = w_as | w_bs; o_y = 32'(w_t); end
      3'b101: begin w_t = w_as & w_bs; o_y = 32'(w_t); end
      3'b110: begin w_t = ~w_as;       o_y = 32'(w_t); end
      default: begin w_t = ~w_bs;      o_y = 32'(w_t); end
    endcase
  end
endmodule

module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0]  req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          r_state, w_state_next;
  logic [ID_W-1:0] r_last_id, r_id, r_rsp_id, w_grant_id;
  logic [15:0]     r_a, r_b, w_sel_a, w_sel_b;
  logic [2:0]      r_op, w_sel_op;
  logic [31:0]     r_rsp_data, w_alu_y;
  logic            r_rsp_err, w_grant_hit, w_accept, w_div_zero;

  // Search upward from last_id+1, wrapping, for the first valid requester.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_hit = 1'b0;
    w_grant_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last_id) + k) % NUM_REQ;
      if (!w_grant_hit && req_valid[ID_W'(idx)]) begin
        w_grant_hit = 1'b1;
        w_grant_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_a  = req_a[16*i +: 16];
        w_sel_b  = req_b[16*i +: 16];
        w_sel_op = req_op[3*i +: 3];
      end
    end
  end

  // Ready is held low while reset is asserted so nothing is accepted during it.
  assign w_accept = (r_state == IDLE) && w_grant_hit && !rst;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant_id] = 1'b1;
  end

  ALU u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_alu_y)
  );

`ifdef ALU_RR_ARBITER_DIVZERO_CHECK_EN
  assign w_div_zero = (r_op == 3'b011) && (r_b == 16'd0);
`else
  assign w_div_zero = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = EXEC;
      EXEC:                   w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_id  <= ID_W'(NUM_REQ - 1);
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a       <= w_sel_a;
        r_b       <= w_sel_b;
        r_op      <= w_sel_op;
        r_id      <= w_grant_id;
        r_last_id <= w_grant_id;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_div_zero ? 32'd0 : w_alu_y;
        r_rsp_err  <= w_div_zero;
        r_rsp_id   <= r_id;
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed vectors, arbitration sequences and a random
// scoreboard run. Honors ALU_RR_ARBITER_DIVZERO_CHECK_EN the same way the design does.

module tb_alu_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk, rst;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [16*NUM_REQ-1:0] req_a, req_b;
  logic [3*NUM_REQ-1:0]  req_op;
  logic                  rsp_valid, rsp_ready, rsp_err, busy;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          id;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rsp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input int id);
    int sa, sb, q, r;
    logic [15:0] t;
    rsp_t m;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = '0;
    m.id = id;
    m.err = 1'b0;
    m.data = '0;
    case (op)
      3'd0: m.data = 32'(sa + sb);
      3'd1: m.data = 32'(sa - sb);
      3'd2: m.data = 32'(sa * sb);
      3'd3: begin
        if (sb == 0) begin
`ifdef ALU_RR_ARBITER_DIVZERO_CHECK_EN
          m.err = 1'b1;
`endif
        end else begin
          q = sa / sb;
          r = sa - q * sb;
          m.data = {q[15:0], r[15:0]};
        end
      end
      3'd4: t = a | b;
      3'd5: t = a & b;
      3'd6: t = ~a;
      default: t = ~b;
    endcase
    if (op >= 3'd4) m.data = {{16{t[15]}}, t};
    return m;
  endfunction

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    req_op[id*3 +: 3]  = op;
    req_valid[id]      = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
  endtask

  // Single request with nothing else pending: checks accept, exact latency and return to idle.
  task automatic run_one(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output rsp_t got);
    set_req(id, op, a, b);
    #1;
    check("one_ready", req_ready, onehot(id));
    tick();
    req_valid = '0;
    check("one_exec_no_valid", rsp_valid, 1'b0);
    check("one_exec_busy", busy, 1'b1);
    tick();
    check("one_rsp_valid", rsp_valid, 1'b1);
    got.data = rsp_data;
    got.id   = int'(rsp_id);
    got.err  = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("one_idle_busy", busy, 1'b0);
    check("one_idle_valid", rsp_valid, 1'b0);
  endtask

  vec_t vecs[9];
  logic [31:0] held_data;
  rsp_t got, exp_r;
  int n, g, last;
  logic [NUM_REQ-1:0] acc_mask;

  initial begin
    vecs[0] = '{0, 3'b000, 16'd5,    16'hFFFD, 32'h0000_0002};
    vecs[1] = '{2, 3'b010, 16'd300,  16'hFF38, 32'hFFFF_15A0};
    vecs[2] = '{1, 3'b011, 16'hFFF9, 16'd2,    32'hFFFD_FFFF};
    vecs[3] = '{3, 3'b001, 16'd100,  16'd250,  32'hFFFF_FF6A};
    vecs[4] = '{0, 3'b100, 16'h00F0, 16'h0F0F, 32'h0000_0FFF};
    vecs[5] = '{2, 3'b101, 16'h8000, 16'hF000, 32'hFFFF_8000};
    vecs[6] = '{1, 3'b110, 16'h1234, 16'h0000, 32'hFFFF_EDCB};
    vecs[7] = '{3, 3'b111, 16'h0000, 16'hFFFF, 32'h0000_0000};
    vecs[8] = '{0, 3'b011, 16'd100,  16'hFFF9, 32'hFFF2_0002};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    #3;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    do_reset();

    // Directed vectors
    foreach (vecs[i]) begin
      run_one(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, got);
      check($sformatf("vec%0d_data", i), got.data, vecs[i].exp);
      check($sformatf("vec%0d_id", i), got.id, vecs[i].id);
      check($sformatf("vec%0d_err", i), got.err, 1'b0);
    end

`ifdef ALU_RR_ARBITER_DIVZERO_CHECK_EN
    run_one(3, 3'b011, 16'd10, 16'd0, got);
    check("divzero_data", got.data, 32'd0);
    check("divzero_err", got.err, 1'b1);
    run_one(2, 3'b011, 16'd10, 16'd3, got);
    check("div_after_zero_data", got.data, 32'h0003_0001);
    check("div_after_zero_err", got.err, 1'b0);
`endif

    // All requesters continuously valid: grants rotate 0,1,2,3,0
    do_reset();
    set_req(0, 3'b000, 16'd10, 16'd20);
    set_req(1, 3'b001, 16'd3,  16'd10);
    set_req(2, 3'b010, 16'hFFFC, 16'd6);
    set_req(3, 3'b100, 16'h0011, 16'h0100);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n = 0;
      while (req_ready == '0 && n < 10) begin tick(); n++; end
      check($sformatf("rr_grant%0d", k), req_ready, onehot(k % NUM_REQ));
      tick();
      n = 0;
      while (!rsp_valid && n < 10) begin tick(); n++; end
      exp_r = model(req_op[(k % NUM_REQ)*3 +: 3], req_a[(k % NUM_REQ)*16 +: 16],
                    req_b[(k % NUM_REQ)*16 +: 16], k % NUM_REQ);
      check($sformatf("rr_rsp_id%0d", k), rsp_id, exp_r.id);
      check($sformatf("rr_rsp_data%0d", k), rsp_data, exp_r.data);
      tick();
    end

    // Consumer stalls for 5 cycles in RESP; last grant was 0, so requester 1 wins next
    rsp_ready = 1'b0;
    #1;
    check("hold_grant", req_ready, onehot(1));
    tick();
    tick();
    exp_r = model(req_op[5:3], req_a[31:16], req_b[31:16], 1);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, exp_r.data);
      check("hold_id", rsp_id, 1);
      check("hold_no_ready", req_ready, '0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hold_release_valid", rsp_valid, 1'b0);
    check("hold_next_grant", req_ready, onehot(2));
    req_valid = '0;
    tick();

    // Reset asserted mid-EXEC discards the in-flight result
    set_req(2, 3'b000, 16'd1, 16'd1);
    #1;
    check("rstexec_grant", req_ready, onehot(2));
    tick();
    check("rstexec_in_exec", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rstexec_busy", busy, 1'b0);
    check("rstexec_valid", rsp_valid, 1'b0);
    check("rstexec_data", rsp_data, 32'd0);
    check("rstexec_id", rsp_id, '0);
    check("rstexec_err", rsp_err, 1'b0);
    check("rstexec_ready", req_ready, '0);
    @(posedge clk);
    #3 rst = 1'b0;
    req_valid = '1;
    #1;
    check("rstexec_first_grant", req_ready, onehot(0));
    req_valid = '0;
    tick();
    check("rstexec_no_rsp", rsp_valid, 1'b0);

    // Random traffic against the scoreboard
    do_reset();
    last = NUM_REQ - 1;
    sb_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [2:0]  op;
      logic [15:0] a, b;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          op = 3'($urandom_range(0, 7));
          a  = 16'($urandom_range(0, 32766) - 16383);
          b  = 16'($urandom_range(0, 32766) - 16383);
`ifdef ALU_RR_ARBITER_DIVZERO_CHECK_EN
          if (op == 3'b011 && $urandom_range(0, 3) == 0) b = 16'd0;
`else
          if (op == 3'b011 && b == 16'd0) b = 16'd1;
`endif
          set_req(i, op, a, b);
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (!busy && req_valid != '0) check("rand_grant", req_ready, onehot(rr_pick(last, req_valid)));
      else                          check("rand_no_ready", req_ready, '0);
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          check("rand_unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          check("rand_rsp_data", rsp_data, sb_q[0].data);
          check("rand_rsp_id", rsp_id, sb_q[0].id);
          check("rand_rsp_err", rsp_err, sb_q[0].err);
          if (rsp_ready) void'(sb_q.pop_front());
        end
      end
      acc_mask = req_ready & req_valid;
      g = -1;
      for (int i = 0; i < NUM_REQ; i++) if (acc_mask[i]) g = i;
      if (g >= 0) begin
        sb_q.push_back(model(req_op[g*3 +: 3], req_a[g*16 +: 16], req_b[g*16 +: 16], g));
        last = g;
      end
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 50) begin
      if (rsp_valid && sb_q.size() != 0) begin
        check("drain_rsp_data", rsp_data, sb_q[0].data);
        check("drain_rsp_id", rsp_id, sb_q[0].id);
        void'(sb_q.pop_front());
      end
      tick();
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
    check("drain_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
